// File: rtl/jedro_1_mem_arbiter.sv
// Two-port (fetch + data) arbiter onto one single-port 1-cycle-latency RAM.
// Latency: grant is combinational, rvalid follows grant by exactly one cycle.
// Backpressure: the losing requester holds req until gnt; contested cycles alternate winners.
module jedro_1_mem_arbiter #(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int CNT_WIDTH  = 16,
    localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,

    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [BE_WIDTH-1:0]   d_be_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [DATA_WIDTH-1:0] d_rdata_o,

    output logic                  ram_en_o,
    output logic [BE_WIDTH-1:0]   ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i,

    output logic [CNT_WIDTH-1:0]  conflict_cnt_o
);

    logic                 prio_q;
    logic                 if_pend_q;
    logic                 d_pend_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic contested;
    logic d_win;
    logic if_win;

    assign contested = if_req_i & d_req_i;
    // prio_q = 1 means data wins a contested cycle
    assign d_win     = d_req_i & (~if_req_i | prio_q);
    assign if_win    = if_req_i & ~d_win;

    assign if_gnt_o  = if_win & ~rst_i;
    assign d_gnt_o   = d_win & ~rst_i;

    assign ram_en_o    = if_gnt_o | d_gnt_o;
    assign ram_addr_o  = d_win ? d_addr_i : if_addr_i;
    assign ram_we_o    = (d_gnt_o & d_we_i) ? d_be_i : '0;
    assign ram_wdata_o = d_wdata_i;

    // A response owed across a reset edge is dropped; the RAM write itself already happened.
    assign if_rvalid_o = if_pend_q & ~rst_i;
    assign d_rvalid_o  = d_pend_q & ~rst_i;
    assign if_rdata_o  = ram_rdata_i;
    assign d_rdata_o   = ram_rdata_i;

    assign conflict_cnt_o = cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q    <= 1'b1;
            if_pend_q <= 1'b0;
            d_pend_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if_pend_q <= if_gnt_o;
            d_pend_q  <= d_gnt_o;
            if (contested) begin
                prio_q <= ~d_win;
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Bench for jedro_1_mem_arbiter: directed vector table, saturation run, then
// randomized traffic checked against a rule-level arbitration and memory model.
module tb_jedro_1_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we;
    logic [BW-1:0] d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          ram_en;
    logic [BW-1:0] ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [CW-1:0] cnt;

    jedro_1_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr),
        .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
        .conflict_cnt_o(cnt)
    );

    // Bytewrite RAM with 1-cycle read latency
    logic [DW-1:0] ram [256];
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= ram[ram_addr[9:2]];
            for (int b = 0; b < BW; b++)
                if (ram_we[b]) ram[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    // Reference model state
    logic [DW-1:0] shadow [256];
    bit            m_valid = 0;
    bit            m_prio, m_ip, m_dp, m_dread;
    logic [DW-1:0] m_data;
    int            m_cnt;
    bit            e_ig, e_dg;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit ir, input logic [AW-1:0] ia,
                        input bit dr, input bit dw, input logic [BW-1:0] db,
                        input logic [AW-1:0] da, input logic [DW-1:0] dd);
        int idx;
        @(negedge clk);
        rst = r; if_req = ir; if_addr = ia;
        d_req = dr; d_we = dw; d_be = db; d_addr = da; d_wdata = dd;
        #1;
        e_dg = !r && dr && (!ir || m_prio);
        e_ig = !r && ir && !e_dg;
        chk("if_gnt", if_gnt, e_ig);
        chk("d_gnt", d_gnt, e_dg);
        chk("ram_en", ram_en, e_ig || e_dg);
        if (e_ig || e_dg) begin
            chk("ram_addr", ram_addr, e_dg ? da : ia);
            chk("ram_we", ram_we, (e_dg && dw) ? db : '0);
            if (e_dg && dw) chk("ram_wdata", ram_wdata, dd);
        end
        if (m_valid) begin
            chk("if_rvalid", if_rvalid, m_ip && !r);
            chk("d_rvalid", d_rvalid, m_dp && !r);
            if (m_ip && !r) chk("if_rdata", if_rdata, m_data);
            if (m_dp && m_dread && !r) chk("d_rdata", d_rdata, m_data);
            chk("conflict_cnt", cnt, m_cnt);
        end
        if (r) begin
            m_valid = 1; m_prio = 1; m_ip = 0; m_dp = 0; m_cnt = 0;
        end else begin
            m_ip = e_ig; m_dp = e_dg; m_dread = e_dg && !dw;
            if (e_ig || e_dg) begin
                idx = int'((e_dg ? da : ia) >> 2) & 255;
                m_data = shadow[idx];
                if (e_dg && dw)
                    for (int b = 0; b < BW; b++)
                        if (db[b]) shadow[idx][8*b +: 8] = dd[8*b +: 8];
            end
            if (ir && dr) begin
                m_prio = !e_dg;
                if (m_cnt < CMAX) m_cnt++;
            end
        end
    endtask

    typedef struct {
        bit r, ir; logic [AW-1:0] ia;
        bit dr, dw; logic [BW-1:0] db; logic [AW-1:0] da; logic [DW-1:0] dd;
        bit eig, edg, eirv, edrv, crd; logic [DW-1:0] erd; int ecnt;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit ir, logic [AW-1:0] ia, bit dr, bit dw,
                                logic [BW-1:0] db, logic [AW-1:0] da, logic [DW-1:0] dd,
                                bit eig, bit edg, bit eirv, bit edrv, bit crd,
                                logic [DW-1:0] erd, int ecnt);
        vec_t v;
        v.r = r; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.db = db; v.da = da; v.dd = dd;
        v.eig = eig; v.edg = edg; v.eirv = eirv; v.edrv = edrv; v.crd = crd; v.erd = erd;
        v.ecnt = ecnt;
        return v;
    endfunction

    bit            hi, hd, hw;
    logic [AW-1:0] hia, hda;
    logic [BW-1:0] hbe;
    logic [DW-1:0] hdd;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i] = 32'hA5000000 | i;
            shadow[i] = 32'hA5000000 | i;
        end
        ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33; ram[4] = 32'h0;
        shadow[0] = 32'h11; shadow[1] = 32'h22; shadow[2] = 32'h33; shadow[4] = 32'h0;
        rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;

        // fetch-only stream
        tbl.push_back(mk(0,1,32'h0,0,0,0,0,0,            1,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,32'h4,0,0,0,0,0,            1,0,1,0,1,32'h11,0));
        tbl.push_back(mk(0,1,32'h8,0,0,0,0,0,            1,0,1,0,1,32'h22,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,                0,0,1,0,1,32'h33,0));
        // full write, byte write, read back
        tbl.push_back(mk(0,0,0,1,1,4'hF,32'h10,32'hDEADBEEF, 0,1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,1,4'h1,32'h10,32'h000000AA, 0,1,0,1,0,0,0));
        tbl.push_back(mk(0,0,0,1,0,0,32'h10,0,           0,1,0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,                0,0,0,1,1,32'hDEADBEAA,0));
        // six contested cycles alternate D, I, D, I, D, I
        for (int k = 0; k < 6; k++)
            tbl.push_back(mk(0,1,32'h0,1,0,0,32'h4,0, k%2, !(k%2), k>0 && !(k%2), k>0 && (k%2),
                             k > 0, (k%2) ? 32'h22 : 32'h11, k));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,                0,0,1,0,1,32'h11,6));
        // uncontested fetch leaves priority with data
        tbl.push_back(mk(0,1,32'h8,0,0,0,0,0,            1,0,0,0,0,0,6));
        tbl.push_back(mk(0,1,32'h0,1,0,0,32'h4,0,        0,1,1,0,1,32'h33,6));
        tbl.push_back(mk(0,1,32'h0,1,0,0,32'h4,0,        1,0,0,1,1,32'h22,7));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,                0,0,1,0,1,32'h11,8));
        // reset right after a data read grant
        tbl.push_back(mk(0,0,0,1,0,0,32'h4,0,            0,1,0,0,0,0,8));
        tbl.push_back(mk(1,1,32'h0,1,0,0,32'h4,0,        0,0,0,0,0,0,8));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,                0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,32'h0,1,0,0,32'h4,0,        0,1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,                0,0,0,1,1,32'h22,1));

        step(1,0,0,0,0,0,0,0);
        step(1,0,0,0,0,0,0,0);
        chk("reset_ram_we", ram_we, '0);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dw, tbl[i].db,
                 tbl[i].da, tbl[i].dd);
            chk($sformatf("vec%0d_if_gnt", i), if_gnt, tbl[i].eig);
            chk($sformatf("vec%0d_d_gnt", i), d_gnt, tbl[i].edg);
            chk($sformatf("vec%0d_if_rvalid", i), if_rvalid, tbl[i].eirv);
            chk($sformatf("vec%0d_d_rvalid", i), d_rvalid, tbl[i].edrv);
            if (tbl[i].crd)
                chk($sformatf("vec%0d_rdata", i), tbl[i].eirv ? if_rdata : d_rdata, tbl[i].erd);
            chk($sformatf("vec%0d_cnt", i), cnt, tbl[i].ecnt);
        end

        // counter saturation
        for (int k = 0; k < 20; k++) step(0,1,32'h0,1,0,0,32'h4,0);
        step(0,0,0,0,0,0,0,0);
        chk("cnt_saturated", cnt, CMAX);

        // randomized traffic; requesters hold their request until granted
        hi = 0; hd = 0; hw = 0; hia = 0; hda = 0; hbe = 0; hdd = 0;
        for (int k = 0; k < 600; k++) begin
            if (!hi && ($urandom_range(0, 3) != 0)) begin
                hi = 1; hia = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            end
            if (!hd && ($urandom_range(0, 2) != 0)) begin
                hd = 1; hw = ($urandom_range(0, 1) == 1);
                hbe = 4'($urandom_range(0, 15));
                hda = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                hdd = $urandom;
            end
            step($urandom_range(0, 49) == 0, hi, hia, hd, hw, hbe, hda, hdd);
            if (e_ig) hi = 0;
            if (e_dg) hd = 0;
        end
        step(0,0,0,0,0,0,0,0);
        step(0,0,0,0,0,0,0,0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jedro_1_mem_arbiter.md
Name: jedro_1_mem_arbiter

Overview:
- Shares one single-port synchronous RAM between the jedro_1 instruction-fetch port and the load/store (data) port.
- The RAM has 1-cycle read latency.
- Grants one requester per cycle, drives the RAM, and routes the response back to the requester that owned the access.
- Sits between jedro_1_top's memory interfaces and a unified bytewrite RAM, allowing a single-memory SoC build.

Parameters:
- ADDR_WIDTH, 32, byte-address width of both requester ports and the RAM port.
- DATA_WIDTH, 32, data width. Must be a multiple of 8. BE_WIDTH = DATA_WIDTH/8.
- CNT_WIDTH, 16, width of the saturating conflict counter.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- if_req_i  in  1  instruction-fetch read request.
- if_addr_i  in  ADDR_WIDTH  fetch byte address.
- if_gnt_o  out  1  fetch request accepted this cycle.
- if_rvalid_o  out  1  fetch read data valid.
- if_rdata_o  out  DATA_WIDTH  fetch read data.
- d_req_i  in  1  data request.
- d_we_i  in  1  1 = write, 0 = read.
- d_be_i  in  BE_WIDTH  byte enables for writes.
- d_addr_i  in  ADDR_WIDTH  data byte address.
- d_wdata_i  in  DATA_WIDTH  write data.
- d_gnt_o  out  1  data request accepted this cycle.
- d_rvalid_o  out  1  data response (read data valid or write done).
- d_rdata_o  out  DATA_WIDTH  data read data.
- ram_en_o  out  1  RAM access enable.
- ram_we_o  out  BE_WIDTH  RAM byte write enables.
- ram_addr_o  out  ADDR_WIDTH  RAM byte address (passed through unchanged).
- ram_wdata_o  out  DATA_WIDTH  RAM write data.
- ram_rdata_i  in  DATA_WIDTH  RAM read data, valid the cycle after ram_en_o.
- conflict_cnt_o  out  CNT_WIDTH  number of cycles with both requests asserted.

Behaviour:
- Protocol: a requester holds req and its address/data stable until it sees gnt. gnt is combinational from req and internal state, in the same cycle.
- Grant rules:
  - Only if_req_i asserted: grant fetch.
  - Only d_req_i asserted: grant data.
  - Both asserted: grant the port selected by prio_q.
  - Neither asserted: no grant, ram_en_o = 0.
- prio_q (1 bit, 1 = data preferred):
  - Reset value 1.
  - Updated only on a contested cycle: set to the loser, so the loser wins the next contested cycle.
  - An uncontested grant leaves prio_q unchanged.
- RAM drive in the grant cycle (combinational from the winner):
  - ram_en_o = 1, ram_addr_o = winner address.
  - ram_we_o = d_be_i if data wins with d_we_i = 1, else 0.
  - ram_wdata_o = d_wdata_i (don't-care when ram_we_o = 0).
- Response tracking: registered owner flags if_pend_q and d_pend_q are set for exactly one cycle after the grant.
  - if_rvalid_o = if_pend_q. d_rvalid_o = d_pend_q.
  - d_rvalid_o also pulses for writes, as a write acknowledge.
  - Latency from gnt to rvalid is exactly 1 cycle.
  - At most one rvalid is asserted in any cycle.
- Read data: if_rdata_o and d_rdata_o both equal ram_rdata_i, qualified only by their rvalid.
- Back-to-back: a new grant is allowed every cycle, including the cycle in which the previous rvalid is asserted. Full throughput is 1 access/cycle.
- conflict_cnt_o: increments by 1 each cycle with if_req_i & d_req_i asserted. Saturates at all-ones and does not wrap.
- Reset (rst_i = 1 at a rising edge), applied regardless of outstanding accesses:
  - prio_q = 1, pending flags = 0, conflict_cnt_o = 0.
  - Gnt and ram_en_o are forced 0 while rst_i is high.
  - An access granted in the cycle before reset still updates the RAM, but its rvalid is suppressed.
- Reset output values: if_gnt_o = 0, d_gnt_o = 0, if_rvalid_o = 0, d_rvalid_o = 0, ram_en_o = 0, ram_we_o = 0, conflict_cnt_o = 0.
- Out of scope: no address decoding, no misalignment checks, no error response.

Test Plan:
- Fetch only: if_req_i held, addresses 0x0, 0x4, 0x8 (RAM preloaded 0x11,0x22,0x33) -> if_gnt_o = 1 every cycle; if_rvalid_o one cycle later with 0x11, 0x22, 0x33; d_rvalid_o stays 0.
- Data write then read: write 0xDEADBEEF to 0x10 with be = 4'b1111, then byte write 0xAA with be = 4'b0001, then read 0x10 -> d_rvalid_o each cycle after its grant; read returns 0xDEADBEAA.
- Contention: both requests held continuously for 6 cycles after reset -> grant order D, I, D, I, D, I; conflict_cnt_o = 6; no starvation.
- Contention after an uncontested grant: I alone, then both requesting -> data wins, since prio_q is unchanged from reset; the next contested cycle goes to I.
- Reset mid-access: grant a data read at 0x4, then assert rst_i the next cycle -> d_rvalid_o = 0; all outputs at reset values; after release, the first contested grant goes to data.
- Saturation: with CNT_WIDTH = 4, hold both requests for 20 cycles -> conflict_cnt_o stops at 15.
